// File: rtl/ip_job_sequencer_pkg.sv
// Shared types and constants for the IP job sequencer and its access generator.
// Optional feature macro used by the sequencer: JOB_TIMEOUT_EN.
package ipseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_PIN,
        ST_WR_DATA,
        ST_SET_POUT,
        ST_START,
        ST_WAIT_DONE,
        ST_RD_DATA,
        ST_CLR_ST
    } state_t;

    typedef enum logic [1:0] {
        ACC_WRITE,
        ACC_READ,
        ACC_START
    } acc_kind_t;

    typedef enum logic {
        PH_SLOT,
        PH_GAP
    } phase_t;

    localparam logic [4:0]  ADDR_MEMIN   = 5'h00;
    localparam logic [4:0]  ADDR_MEMOUT  = 5'h01;
    localparam logic [4:0]  ADDR_PTR_IN  = 5'h02;
    localparam logic [4:0]  ADDR_PTR_OUT = 5'h03;
    localparam logic [4:0]  ADDR_STATUS  = 5'h1E;
    localparam logic [4:0]  ADDR_ID      = 5'h1F;
    localparam logic [31:0] CLR_WORD     = 32'h0001_0001;
    localparam logic [15:0] TIMEOUT_MAX  = 16'hFFFF;

endpackage

// File: rtl/ip_job_sequencer_if.sv
// Bundles the job, stream and IP-side signals of the sequencer.
// master = the sequencer itself, slave = the surrounding system and IP.
interface ip_job_sequencer_if;

    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_in_ptr;
    logic [31:0] job_out_ptr;
    logic [7:0]  job_num_in;
    logic [7:0]  job_num_out;

    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;

    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;

    logic [4:0]  conf_dbus;
    logic [31:0] data_in;
    logic        write;
    logic        read;
    logic        start;
    logic [31:0] data_out;
    logic        int_done;

    modport master (
        input  job_valid, job_in_ptr, job_out_ptr, job_num_in, job_num_out,
        output job_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output conf_dbus, data_in, write, read, start,
        input  data_out, int_done
    );

    modport slave (
        output job_valid, job_in_ptr, job_out_ptr, job_num_in, job_num_out,
        input  job_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  conf_dbus, data_in, write, read, start,
        output data_out, int_done
    );

endinterface

// File: rtl/ip_job_sequencer_access.sv
// Strobe/gap generator: each granted request becomes one strobe cycle followed
// by one gap cycle, with conf_dbus held across both.
module ipseq_access
    import ipseq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_a,
    input  logic        req,
    input  acc_kind_t   kind,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        slot,
    output logic        fire,
    output logic        done,
    output logic        write,
    output logic        read,
    output logic        start,
    output logic [4:0]  conf_dbus,
    output logic [31:0] data_in
);

    phase_t     phase, phase_nxt;
    logic [4:0] addr_q;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            phase  <= PH_SLOT;
            addr_q <= '0;
        end else begin
            phase <= phase_nxt;
            if (fire)
                addr_q <= addr;
        end
    end

    // Strobe outputs are combinational so a stream handshake and its strobe share a cycle.
    always_comb begin
        phase_nxt = phase;
        slot      = (phase == PH_SLOT);
        fire      = 1'b0;
        done      = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        start     = 1'b0;
        conf_dbus = 5'h00;
        data_in   = 32'h0;
        case (phase)
            PH_SLOT: begin
                if (req) begin
                    fire      = 1'b1;
                    write     = (kind == ACC_WRITE);
                    read      = (kind == ACC_READ);
                    start     = (kind == ACC_START);
                    conf_dbus = addr;
                    data_in   = (kind == ACC_WRITE) ? wdata : 32'h0;
                    phase_nxt = PH_GAP;
                end
            end
            PH_GAP: begin
                done      = 1'b1;
                conf_dbus = addr_q;
                phase_nxt = PH_SLOT;
            end
            default: phase_nxt = PH_SLOT;
        endcase
    end

endmodule

// File: rtl/ip_job_sequencer.sv
// Job sequencer: programs pointers, streams words into the IP, starts it, waits
// for completion, streams results out and clears status. Optional: JOB_TIMEOUT_EN.
module ip_job_sequencer
    import ipseq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_a,
    ip_job_sequencer_if.master bus,
    output logic               busy,
    output logic               err
);

    state_t      state, state_nxt;
    logic [31:0] in_ptr;
    logic [31:0] out_ptr;
    logic [7:0]  in_cnt;
    logic [7:0]  out_cnt;
    logic        live;
    logic        accept;
    logic        timeout;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    logic        acc_req;
    acc_kind_t   acc_kind;
    logic [4:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_slot;
    logic        acc_fire;
    logic        acc_done;

    assign bus.job_ready = live && (state == ST_IDLE);
    assign accept        = bus.job_valid && bus.job_ready;
    assign busy          = (state != ST_IDLE);
    assign bus.wr_ready  = wr_ready;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_data;

    ipseq_access u_access (
        .clk       (clk),
        .rst_a     (rst_a),
        .req       (acc_req),
        .kind      (acc_kind),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .slot      (acc_slot),
        .fire      (acc_fire),
        .done      (acc_done),
        .write     (bus.write),
        .read      (bus.read),
        .start     (bus.start),
        .conf_dbus (bus.conf_dbus),
        .data_in   (bus.data_in)
    );

`ifdef JOB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_q;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != ST_WAIT_DONE)
                wait_cnt <= '0;
            else if (wait_cnt != TIMEOUT_MAX)
                wait_cnt <= wait_cnt + 16'd1;
            if (accept)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    assign timeout = (state == ST_WAIT_DONE) && !bus.int_done && (wait_cnt == TIMEOUT_MAX);
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state    <= ST_IDLE;
            live     <= 1'b0;
            in_ptr   <= '0;
            out_ptr  <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            if (accept) begin
                in_ptr  <= bus.job_in_ptr;
                out_ptr <= bus.job_out_ptr;
                in_cnt  <= bus.job_num_in;
                out_cnt <= bus.job_num_out;
            end
            if (state == ST_WR_DATA && acc_fire && in_cnt != 8'd0)
                in_cnt <= in_cnt - 8'd1;
            // The IP returns read data one cycle after the strobe, i.e. in the gap cycle.
            if (state == ST_RD_DATA && acc_done) begin
                rd_data  <= bus.data_out;
                rd_valid <= 1'b1;
                if (out_cnt != 8'd0)
                    out_cnt <= out_cnt - 8'd1;
            end else if (rd_valid && bus.rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acc_req   = 1'b0;
        acc_kind  = ACC_WRITE;
        acc_addr  = ADDR_MEMIN;
        acc_wdata = 32'h0;
        wr_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = ST_SET_PIN;
            end
            ST_SET_PIN: begin
                acc_req   = 1'b1;
                acc_addr  = ADDR_PTR_IN;
                acc_wdata = in_ptr;
                if (acc_done)
                    state_nxt = (in_cnt == 8'd0) ? ST_SET_POUT : ST_WR_DATA;
            end
            ST_WR_DATA: begin
                wr_ready  = acc_slot;
                acc_req   = bus.wr_valid;
                acc_addr  = ADDR_MEMIN;
                acc_wdata = bus.wr_data;
                if (acc_done && in_cnt == 8'd0)
                    state_nxt = ST_SET_POUT;
            end
            ST_SET_POUT: begin
                acc_req   = 1'b1;
                acc_addr  = ADDR_PTR_OUT;
                acc_wdata = out_ptr;
                if (acc_done)
                    state_nxt = ST_START;
            end
            ST_START: begin
                acc_req  = 1'b1;
                acc_kind = ACC_START;
                if (acc_done)
                    state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.int_done)
                    state_nxt = (out_cnt == 8'd0) ? ST_CLR_ST : ST_RD_DATA;
                else if (timeout)
                    state_nxt = ST_CLR_ST;
            end
            ST_RD_DATA: begin
                // Hold off the next read until the previous word has left the output register.
                acc_req  = !rd_valid && (out_cnt != 8'd0);
                acc_kind = ACC_READ;
                acc_addr = ADDR_MEMOUT;
                if (out_cnt == 8'd0 && !rd_valid)
                    state_nxt = ST_CLR_ST;
            end
            ST_CLR_ST: begin
                acc_req   = 1'b1;
                acc_addr  = ADDR_STATUS;
                acc_wdata = CLR_WORD;
                if (acc_done)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ip_job_sequencer.sv
// Scoreboard bench for ip_job_sequencer: expected IP accesses and output words
// are queued when a job is launched and checked as the DUT produces them.
module tb_ip_job_sequencer;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic clk;
    logic rst_a;
    logic busy;
    logic err;

    int checks;
    int errors;
    int ip_word;
    int rd_seq;

    acc_t        exp_acc[$];
    logic [31:0] exp_rd[$];

    logic        prev_strobe;
    logic [4:0]  prev_conf;
    acc_t        mon_e;
    logic [1:0]  mon_kind;
    int          mon_cnt;

    ip_job_sequencer_if bus();

    ip_job_sequencer dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IP model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.read) begin
            bus.data_out <= 32'hC0DE_0000 + ip_word;
            ip_word      <= ip_word + 1;
        end
    end

    function automatic acc_t mk(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
        acc_t r;
        r.kind = k;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic logic [31:0] wword(input logic [31:0] ptr, input int k);
        return 32'hD000_0000 + (ptr << 4) + k;
    endfunction

    // Access monitor: pops the expected-access queue on every strobe and checks gap cycles.
    always @(negedge clk) begin
        if (rst_a) begin
            mon_cnt = int'(bus.write) + int'(bus.read) + int'(bus.start);
            if (prev_strobe) begin
                checks++;
                if (mon_cnt != 0 || bus.conf_dbus !== prev_conf) begin
                    errors++;
                    $display("[TB] FAIL gap: strobes=%0d conf=%h required strobes=0 conf=%h", mon_cnt, bus.conf_dbus, prev_conf);
                end
            end
            if (!bus.write) begin
                checks++;
                if (bus.data_in !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL data_in_idle: got %h required 0", bus.data_in);
                end
            end
            if (mon_cnt != 0) begin
                mon_kind = (mon_cnt > 1) ? 2'd3 : bus.write ? 2'd0 : bus.read ? 2'd1 : 2'd2;
                checks++;
                if (exp_acc.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_access: kind=%0d conf=%h data=%h", mon_kind, bus.conf_dbus, bus.data_in);
                end else begin
                    mon_e = exp_acc.pop_front();
                    if (mon_kind !== mon_e.kind ||
                        (mon_e.kind != 2'd2 && bus.conf_dbus !== mon_e.addr) ||
                        (mon_e.kind == 2'd0 && bus.data_in !== mon_e.data)) begin
                        errors++;
                        $display("[TB] FAIL access: got kind=%0d conf=%h data=%h required kind=%0d conf=%h data=%h",
                                 mon_kind, bus.conf_dbus, bus.data_in, mon_e.kind, mon_e.addr, mon_e.data);
                    end
                end
            end
            prev_strobe = (mon_cnt != 0);
            prev_conf   = bus.conf_dbus;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic launch(input logic [31:0] ip, input logic [31:0] op,
                          input logic [7:0] ni, input logic [7:0] no, input bit noise);
        int n;
        @(negedge clk);
        if (noise) begin
            bus.int_done = 1'b1;
            @(negedge clk);
            bus.int_done = 1'b0;
        end
        bus.job_valid   = 1'b1;
        bus.job_in_ptr  = ip;
        bus.job_out_ptr = op;
        bus.job_num_in  = ni;
        bus.job_num_out = no;
        n = 0;
        while (!bus.job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.job_ready) begin
            errors++;
            $display("[TB] FAIL job_accept: job_ready=%b required 1", bus.job_ready);
        end
        @(negedge clk);
        bus.job_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_accept: busy=%b err=%b required busy=1 err=0", busy, err);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!bus.start && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.start) begin
            errors++;
            $display("[TB] FAIL start_seen: start=%b required 1", bus.start);
        end
    endtask

    task automatic run_job(input logic [31:0] ip, input logic [31:0] op,
                           input logic [7:0] ni, input logic [7:0] no,
                           input bit stall, input bit noise);
        int n;
        logic [31:0] held;
        logic [31:0] e;
        exp_acc.push_back(mk(2'd0, 5'h02, ip));
        for (int k = 0; k < int'(ni); k++)
            exp_acc.push_back(mk(2'd0, 5'h00, wword(ip, k)));
        exp_acc.push_back(mk(2'd0, 5'h03, op));
        exp_acc.push_back(mk(2'd2, 5'h00, 32'h0));
        for (int k = 0; k < int'(no); k++) begin
            exp_acc.push_back(mk(2'd1, 5'h01, 32'h0));
            exp_rd.push_back(32'hC0DE_0000 + rd_seq);
            rd_seq++;
        end
        exp_acc.push_back(mk(2'd0, 5'h1E, 32'h0001_0001));

        launch(ip, op, ni, no, noise);

        for (int k = 0; k < int'(ni); k++) begin
            if (stall && k == 1) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.write !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL wr_stall: write=%b busy=%b required write=0 busy=1", bus.write, busy);
                    end
                end
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wword(ip, k);
            n = 0;
            while (!bus.wr_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!bus.wr_ready) begin
                errors++;
                $display("[TB] FAIL wr_handshake: wr_ready=%b required 1", bus.wr_ready);
            end
            @(negedge clk);
            bus.wr_valid = 1'b0;
            bus.wr_data  = 32'h0;
            if (noise && k == 0) begin
                bus.int_done = 1'b1;
                @(negedge clk);
                bus.int_done = 1'b0;
            end
        end

        wait_start();
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || bus.read !== 1'b0 || bus.job_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wait_hold: busy=%b read=%b job_ready=%b required 1 0 0", busy, bus.read, bus.job_ready);
            end
        end
        bus.int_done = 1'b1;
        @(negedge clk);
        bus.int_done = 1'b0;

        for (int k = 0; k < int'(no); k++) begin
            n = 0;
            while (!bus.rd_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (stall && k == 1) begin
                held = bus.rd_data;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.rd_valid !== 1'b1 || bus.rd_data !== held || bus.read !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL rd_stall: rd_valid=%b rd_data=%h read=%b required 1 %h 0", bus.rd_valid, bus.rd_data, bus.read, held);
                    end
                end
            end
            e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                errors++;
                $display("[TB] FAIL rd_data: rd_valid=%b rd_data=%h required 1 %h", bus.rd_valid, bus.rd_data, e);
            end
            bus.rd_ready = 1'b1;
            @(negedge clk);
            bus.rd_ready = 1'b0;
        end

        n = 0;
        while (!bus.job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.job_ready || busy !== 1'b0 || err !== 1'b0 || exp_acc.size() != 0) begin
            errors++;
            $display("[TB] FAIL job_end: job_ready=%b busy=%b err=%b pending=%0d required 1 0 0 0",
                     bus.job_ready, busy, err, exp_acc.size());
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || bus.write !== 1'b0 || bus.read !== 1'b0 ||
            bus.start !== 1'b0 || bus.conf_dbus !== 5'h0 || bus.data_in !== 32'h0 ||
            bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: busy=%b err=%b w=%b r=%b s=%b conf=%h din=%h rdv=%b rdd=%h wrr=%b required all 0",
                     tag, busy, err, bus.write, bus.read, bus.start, bus.conf_dbus, bus.data_in,
                     bus.rd_valid, bus.rd_data, bus.wr_ready);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        #2 rst_a = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: job_ready=%b busy=%b required 1 0", bus.job_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_job(32'h10, 32'h20, 8'd2, 8'd2, 1'b0, 1'b0);
    endtask

    task automatic test_zero_counts();
        run_job(32'h44, 32'h88, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        run_job(32'h100, 32'h200, 8'd4, 8'd3, 1'b1, 1'b0);
    endtask

    task automatic test_done_noise();
        run_job(32'h31, 32'h62, 8'd3, 8'd1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_job();
        exp_acc.push_back(mk(2'd0, 5'h02, 32'h55));
        exp_acc.push_back(mk(2'd0, 5'h03, 32'h66));
        exp_acc.push_back(mk(2'd2, 5'h00, 32'h0));
        launch(32'h55, 32'h66, 8'd0, 8'd1, 1'b0);
        wait_start();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || exp_acc.size() != 0) begin
            errors++;
            $display("[TB] FAIL pre_reset: busy=%b pending=%0d required 1 0", busy, exp_acc.size());
        end
        #2 rst_a = 1'b0;
        #1 check_all_zero("mid_job_reset");
        exp_acc.delete();
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.job_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: job_ready=%b busy=%b required 1 0", bus.job_ready, busy);
        end
        run_job(32'h77, 32'h99, 8'd1, 8'd2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(32'hA0, 32'hB0, 8'd1, 8'd1, 1'b0, 1'b0);
        run_job(32'hA1, 32'hB1, 8'd2, 8'd0, 1'b0, 1'b0);
    endtask

`ifdef JOB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        exp_acc.push_back(mk(2'd0, 5'h02, 32'hE0));
        exp_acc.push_back(mk(2'd0, 5'h03, 32'hF0));
        exp_acc.push_back(mk(2'd2, 5'h00, 32'h0));
        exp_acc.push_back(mk(2'd0, 5'h1E, 32'h0001_0001));
        launch(32'hE0, 32'hF0, 8'd0, 8'd2, 1'b0);
        n = 0;
        while (!bus.job_ready && n < 70000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.job_ready || err !== 1'b1 || exp_acc.size() != 0 || n < 65535) begin
            errors++;
            $display("[TB] FAIL timeout: job_ready=%b err=%b pending=%0d cycles=%0d required 1 1 0 >=65535",
                     bus.job_ready, err, exp_acc.size(), n);
        end
        run_job(32'hE1, 32'hF1, 8'd1, 8'd1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        checks          = 0;
        errors          = 0;
        ip_word         = 0;
        rd_seq          = 0;
        prev_strobe     = 1'b0;
        prev_conf       = 5'h0;
        rst_a           = 1'b0;
        bus.job_valid   = 1'b0;
        bus.job_in_ptr  = 32'h0;
        bus.job_out_ptr = 32'h0;
        bus.job_num_in  = 8'd0;
        bus.job_num_out = 8'd0;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = 32'h0;
        bus.rd_ready    = 1'b0;
        bus.int_done    = 1'b0;
        bus.data_out    = 32'h0;

        test_reset();
        test_basic();
        test_zero_counts();
        test_stalls();
        test_done_noise();
        test_reset_mid_job();
        test_back_to_back();
`ifdef JOB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_job_sequencer.md
IP_JOB_SEQUENCER -- requirements
Module: ip_job_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: rst_a  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have job ports: job_valid in 1, job_ready out 1, job_in_ptr in 32, job_out_ptr in 32, job_num_in in 8, job_num_out in 8.
REQ-004 SHALL have input stream ports: wr_valid in 1, wr_ready out 1, wr_data in 32; one word per handshake.
REQ-005 SHALL have output stream ports: rd_valid out 1, rd_ready in 1, rd_data out 32.
REQ-006 SHALL have IP-side ports: conf_dbus out 5, data_in out 32, write out 1, read out 1, start out 1, data_out in 32, int_done in 1.
REQ-007 SHALL have status ports: busy out 1, err out 1 (sticky).

Function
REQ-008 SHALL accept a job when job_valid&&job_ready; job_ready=1 only in IDLE; job fields latched on acceptance.
REQ-009 SHALL sequence states IDLE -> SET_PIN -> WR_DATA -> SET_POUT -> START -> WAIT_DONE -> RD_DATA -> CLR_ST -> IDLE.
REQ-010 SHALL issue every IP access as one strobe cycle (write/read/start = 1) followed by exactly one gap cycle with strobe 0; conf_dbus held through both.
REQ-011 SHALL drive data_in only during a write strobe; 0 otherwise.
REQ-012 SET_PIN SHALL write job_in_ptr to conf_dbus ADDR_PTR_IN; SET_POUT SHALL write job_out_ptr to ADDR_PTR_OUT.
REQ-013 WR_DATA SHALL transfer job_num_in words: wr_ready=1 for one cycle only when in a strobe slot; handshake cycle is the write strobe to ADDR_MEMIN with data_in=wr_data; no strobe while wr_valid=0.
REQ-014 START SHALL pulse start for one cycle then one gap cycle.
REQ-015 WAIT_DONE SHALL remain until int_done=1 sampled; int_done outside WAIT_DONE ignored.
REQ-016 RD_DATA SHALL transfer job_num_out words: read strobe to ADDR_MEMOUT at cycle t, data_out captured at t+1 into rd_data with rd_valid=1; rd_data/rd_valid held stable until rd_ready; next read strobe not before acceptance.
REQ-017 CLR_ST SHALL write ADDR_STATUS with data_in={16'h0001 mask,16'h0001 clear}.
REQ-018 job_num_in=0 SHALL skip WR_DATA; job_num_out=0 SHALL skip RD_DATA; remaining states unchanged.
REQ-019 word counters SHALL be 8-bit down-counters loaded from job fields; state exit at count 0; no wrap.
REQ-020 busy SHALL be 1 in every state except IDLE.

Reset
REQ-021 rst_a low SHALL force IDLE at once, including mid-job; all outputs 0 except job_ready=1 after release; err cleared; counters 0; partial job discarded.

Configuration
REQ-022 JOB_TIMEOUT_EN defined: WAIT_DONE SHALL run a 16-bit cycle counter; at 16'hFFFF without int_done, set err, skip RD_DATA, go to CLR_ST.
REQ-023 JOB_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely; err tied 0.
REQ-024 err (when enabled) SHALL clear only on reset or acceptance of the next job.

Structure
REQ-025 shared package ipseq_pkg SHALL hold: state enum; ADDR_MEMIN=5'h00, ADDR_MEMOUT=5'h01, ADDR_PTR_IN=5'h02, ADDR_PTR_OUT=5'h03, ADDR_STATUS=5'h1E, ADDR_ID=5'h1F; CLR_WORD=32'h0001_0001; TIMEOUT_MAX=16'hFFFF.
REQ-026 SHALL instantiate one sub-module ipseq_access: strobe/gap generator (req in, done out, strobe kind, conf_dbus, data_in).

Verification
REQ-027 job in_ptr=0x10, out_ptr=0x20, num_in=2, num_out=2 -> writes 0x02/0x10, 0x00 x2, 0x03/0x20, start, wait, reads 0x01 x2, 0x1E/0x0001_0001; busy 1 throughout.
REQ-028 num_in=0, num_out=0 -> only ptr writes, start, done wait, status clear; no read/MEMIN strobes.
REQ-029 wr_valid low 5 cycles mid WR_DATA, rd_ready low 4 cycles mid RD_DATA -> no strobes during stall; rd_data stable; word order preserved.
REQ-030 rst_a asserted in WAIT_DONE -> all outputs 0 same cycle; after release job_ready=1, new job runs cleanly.
REQ-031 JOB_TIMEOUT_EN, int_done never asserted -> after 65535 cycles err=1, no read strobes, status clear issued, IDLE; next job acceptance clears err.
REQ-032 int_done pulsed in IDLE and WR_DATA -> ignored; sequencer still waits in WAIT_DONE.
